// File: rtl/alarm_pkg.sv
// Shared alarm types: FSM state encoding and time-of-day limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_RINGING = 2'b10,
    ST_SNOOZE  = 2'b11
  } state_e;

  localparam logic [7:0] MAX_HR  = 8'd23;
  localparam logic [7:0] MAX_MIN = 8'd59;

  // True when hr:min is a legal time of day.
  function automatic logic time_valid(input logic [7:0] hr, input logic [7:0] mn);
    return (hr <= MAX_HR) && (mn <= MAX_MIN);
  endfunction

endpackage

// File: rtl/time_add_wrap.sv
// Combinational hr:min + add_min minutes, wrapping minutes at 60 and hours at 24.
// Assumes a legal input time and add_min in 0..59, so at most one carry occurs.
module time_add_wrap
  import alarm_pkg::*;
(
  input  logic [7:0] hr_in,
  input  logic [7:0] min_in,
  input  logic [7:0] add_min,
  output logic [7:0] hr_out,
  output logic [7:0] min_out
);

  logic [7:0] min_sum;
  logic [7:0] hr_sum;

  // Add minutes, carry into the hour, then wrap the hour past midnight.
  always_comb begin
    min_sum = min_in + add_min;
    hr_sum  = hr_in;
    if (min_sum > MAX_MIN) begin
      min_sum = min_sum - 8'd60;
      hr_sum  = hr_in + 8'd1;
    end
    if (hr_sum > MAX_HR) begin
      hr_sum = hr_sum - 8'd24;
    end
    min_out = min_sum;
    hr_out  = hr_sum;
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm stage: compares time-of-day against a programmed alarm time and drives
// the ring request with snooze, snooze limit, stop and ring auto-timeout.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN       = 5,
  parameter int unsigned MAX_SNOOZE       = 3,
  parameter int unsigned RING_TIMEOUT_SEC = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [7:0] countHr,
  input  logic [7:0] countMin,
  input  logic [7:0] countSec,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic [7:0] alarm_hr_in,
  input  logic [7:0] alarm_min_in,
  input  logic       snooze,
  input  logic       stop,
  output logic       alarm_ring,
  output logic       snooze_active,
  output logic [7:0] alarm_hr,
  output logic [7:0] alarm_min,
  output logic       set_err
);

  localparam logic [7:0] SNOOZE_MIN_W = 8'(SNOOZE_MIN);
  localparam logic [7:0] MAX_SNOOZE_W = 8'(MAX_SNOOZE);
  localparam logic [7:0] TIMEOUT_W    = 8'(RING_TIMEOUT_SEC);

  state_e     state_q, state_d;
  logic [7:0] alarm_hr_q, alarm_hr_d;
  logic [7:0] alarm_min_q, alarm_min_d;
  logic [7:0] snz_hr_q, snz_hr_d;
  logic [7:0] snz_min_q, snz_min_d;
  logic [7:0] snooze_cnt_q, snooze_cnt_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       alarm_ring_q, alarm_ring_d;
  logic       set_err_q, set_err_d;

  logic [7:0] snz_hr_next;
  logic [7:0] snz_min_next;
  logic [7:0] ring_cnt_inc;
  logic       set_ok;
  logic       at_sec0;
  logic       alarm_match;
  logic       snz_match;

  time_add_wrap u_snz_add (
    .hr_in   (countHr),
    .min_in  (countMin),
    .add_min (SNOOZE_MIN_W),
    .hr_out  (snz_hr_next),
    .min_out (snz_min_next)
  );

  // Next-state logic; the if/else order inside each state encodes event priority.
  always_comb begin
    state_d      = state_q;
    alarm_hr_d   = alarm_hr_q;
    alarm_min_d  = alarm_min_q;
    snz_hr_d     = snz_hr_q;
    snz_min_d    = snz_min_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_cnt_d   = ring_cnt_q;
    set_err_d    = 1'b0;

    set_ok       = set_alarm && time_valid(alarm_hr_in, alarm_min_in);
    at_sec0      = tick_1hz && (countSec == 8'd0);
    alarm_match  = at_sec0 && (countHr == alarm_hr_q) && (countMin == alarm_min_q);
    snz_match    = at_sec0 && (countHr == snz_hr_q) && (countMin == snz_min_q);
    ring_cnt_inc = ring_cnt_q + 8'd1;

    if (set_ok) begin
      alarm_hr_d  = alarm_hr_in;
      alarm_min_d = alarm_min_in;
    end else if (set_alarm) begin
      set_err_d = 1'b1;
    end

    if (!alarm_en) begin
      state_d      = ST_IDLE;
      snooze_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (alarm_match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (set_ok || stop) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else if (tick_1hz && (ring_cnt_inc >= TIMEOUT_W)) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else if (snooze) begin
            if (snooze_cnt_q < MAX_SNOOZE_W) begin
              state_d      = ST_SNOOZE;
              snz_hr_d     = snz_hr_next;
              snz_min_d    = snz_min_next;
              snooze_cnt_d = snooze_cnt_q + 8'd1;
            end else begin
              state_d      = ST_ARMED;
              snooze_cnt_d = '0;
            end
          end else if (tick_1hz) begin
            ring_cnt_d = ring_cnt_inc;
          end
        end
        ST_SNOOZE: begin
          if (set_ok || stop) begin
            state_d      = ST_ARMED;
            snooze_cnt_d = '0;
          end else if (snz_match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Ring follows the next state so it rises on the edge that enters RINGING.
    alarm_ring_d = (state_d == ST_RINGING);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      alarm_hr_q   <= '0;
      alarm_min_q  <= '0;
      snz_hr_q     <= '0;
      snz_min_q    <= '0;
      snooze_cnt_q <= '0;
      ring_cnt_q   <= '0;
      alarm_ring_q <= 1'b0;
      set_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_hr_q   <= alarm_hr_d;
      alarm_min_q  <= alarm_min_d;
      snz_hr_q     <= snz_hr_d;
      snz_min_q    <= snz_min_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      alarm_ring_q <= alarm_ring_d;
      set_err_q    <= set_err_d;
    end
  end

  assign alarm_ring    = alarm_ring_q;
  assign snooze_active = (state_q == ST_SNOOZE);
  assign alarm_hr      = alarm_hr_q;
  assign alarm_min     = alarm_min_q;
  assign set_err       = set_err_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: a behavioural model pushes the
// expected outputs for every driven cycle into a queue, popped after the edge.
module tb_alarm_controller;

  localparam int unsigned SNOOZE_MIN       = 5;
  localparam int unsigned MAX_SNOOZE       = 3;
  localparam int unsigned RING_TIMEOUT_SEC = 60;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [7:0] countHr, countMin, countSec;
  logic       alarm_en, set_alarm, snooze, stop;
  logic [7:0] alarm_hr_in, alarm_min_in;
  logic       alarm_ring, snooze_active, set_err;
  logic [7:0] alarm_hr, alarm_min;

  always #5 clk = ~clk;

  alarm_controller #(
    .SNOOZE_MIN       (SNOOZE_MIN),
    .MAX_SNOOZE       (MAX_SNOOZE),
    .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_1hz      (tick_1hz),
    .countHr       (countHr),
    .countMin      (countMin),
    .countSec      (countSec),
    .alarm_en      (alarm_en),
    .set_alarm     (set_alarm),
    .alarm_hr_in   (alarm_hr_in),
    .alarm_min_in  (alarm_min_in),
    .snooze        (snooze),
    .stop          (stop),
    .alarm_ring    (alarm_ring),
    .snooze_active (snooze_active),
    .alarm_hr      (alarm_hr),
    .alarm_min     (alarm_min),
    .set_err       (set_err)
  );

  typedef struct packed {
    logic       ring;
    logic       snz;
    logic [7:0] hr;
    logic [7:0] mn;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int m_st = M_IDLE;
  int m_ahr = 0, m_amin = 0, m_shr = 0, m_smin = 0, m_scnt = 0, m_rcnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    exp_t e;
    bit   valid, m_alarm, m_snz;
    int   h, m, s, t;
    h = int'(countHr); m = int'(countMin); s = int'(countSec);
    valid   = set_alarm && (alarm_hr_in <= 23) && (alarm_min_in <= 59);
    m_alarm = tick_1hz && (s == 0) && (h == m_ahr) && (m == m_amin);
    m_snz   = tick_1hz && (s == 0) && (h == m_shr) && (m == m_smin);
    e.err   = 1'b0;
    if (reset) begin
      m_st = M_IDLE; m_ahr = 0; m_amin = 0; m_shr = 0; m_smin = 0; m_scnt = 0; m_rcnt = 0;
    end else begin
      e.err = set_alarm && !valid;
      if (valid) begin
        m_ahr = int'(alarm_hr_in); m_amin = int'(alarm_min_in);
      end
      if (!alarm_en) begin
        m_st = M_IDLE; m_scnt = 0;
      end else if (m_st == M_IDLE) begin
        m_st = M_ARMED;
      end else if (m_st == M_ARMED) begin
        if (m_alarm) begin m_st = M_RING; m_rcnt = 0; end
      end else if (m_st == M_RING) begin
        if (valid || stop) begin
          m_st = M_ARMED; m_scnt = 0;
        end else if (tick_1hz && (m_rcnt + 1 >= int'(RING_TIMEOUT_SEC))) begin
          m_st = M_ARMED; m_scnt = 0;
        end else if (snooze) begin
          if (m_scnt < int'(MAX_SNOOZE)) begin
            t = (h * 60 + m + int'(SNOOZE_MIN)) % 1440;
            m_shr = t / 60; m_smin = t % 60;
            m_scnt++;
            m_st = M_SNZ;
          end else begin
            m_st = M_ARMED; m_scnt = 0;
          end
        end else if (tick_1hz) begin
          m_rcnt++;
        end
      end else begin
        if (valid || stop) begin
          m_st = M_ARMED; m_scnt = 0;
        end else if (m_snz) begin
          m_st = M_RING; m_rcnt = 0;
        end
      end
    end
    e.ring = (m_st == M_RING);
    e.snz  = (m_st == M_SNZ);
    e.hr   = 8'(m_ahr);
    e.mn   = 8'(m_amin);
    exp_q.push_back(e);
  endtask

  // One clock: push expectation, clock the DUT, pop and compare, drop pulses.
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("sb_ring", alarm_ring, e.ring);
      check_val("sb_snz", snooze_active, e.snz);
      check_val("sb_hr", alarm_hr, e.hr);
      check_val("sb_min", alarm_min, e.mn);
      check_val("sb_err", set_err, e.err);
    end
    tick_1hz = 1'b0; set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0;
  endtask

  task automatic do_tick(input int h, input int m, input int s);
    countHr = 8'(h); countMin = 8'(m); countSec = 8'(s);
    tick_1hz = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic pulse_set(input int h, input int m);
    alarm_hr_in = 8'(h); alarm_min_in = 8'(m); set_alarm = 1'b1;
    cyc();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cyc();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b0; set_alarm = 1'b0;
    snooze = 1'b0; stop = 1'b0; countHr = '0; countMin = '0; countSec = '0;
    alarm_hr_in = '0; alarm_min_in = '0;
    #2;
    cyc(); cyc();
    check_val("rst_ring", alarm_ring, 0);
    check_val("rst_snz", snooze_active, 0);
    check_val("rst_hr", alarm_hr, 0);
    check_val("rst_err", set_err, 0);
    reset = 1'b0; alarm_en = 1'b1;
    cyc();

    // Basic match at 07:30:00 then stop
    pulse_set(7, 30);
    check_val("set_hr", alarm_hr, 7);
    check_val("set_min", alarm_min, 30);
    do_tick(7, 29, 58);
    do_tick(7, 29, 59);
    check_val("pre_match_ring", alarm_ring, 0);
    do_tick(7, 30, 0);
    check_val("match_ring", alarm_ring, 1);
    pulse_stop();
    check_val("stop_ring", alarm_ring, 0);

    // Snooze across midnight: 23:58 + 5 -> 00:03
    pulse_set(23, 58);
    do_tick(23, 57, 59);
    do_tick(23, 58, 0);
    check_val("ring_2358", alarm_ring, 1);
    pulse_snooze();
    check_val("snz1_active", snooze_active, 1);
    check_val("snz1_ring", alarm_ring, 0);
    do_tick(23, 59, 0);
    do_tick(0, 0, 0);
    do_tick(0, 2, 59);
    check_val("snz_wait_ring", alarm_ring, 0);
    do_tick(0, 3, 0);
    check_val("wrap_ring", alarm_ring, 1);
    check_val("wrap_snz", snooze_active, 0);

    // Snooze limit: second and third snooze accepted, fourth acts as stop
    pulse_snooze();
    do_tick(0, 7, 59);
    do_tick(0, 8, 0);
    check_val("snz2_ring", alarm_ring, 1);
    pulse_snooze();
    check_val("snz3_active", snooze_active, 1);
    do_tick(0, 12, 59);
    do_tick(0, 13, 0);
    check_val("snz3_ring", alarm_ring, 1);
    pulse_snooze();
    check_val("max_snz_ring", alarm_ring, 0);
    check_val("max_snz_active", snooze_active, 0);

    // Snooze count was cleared: a new event accepts a snooze again
    pulse_set(7, 30);
    do_tick(7, 29, 59);
    do_tick(7, 30, 0);
    check_val("evt_ring", alarm_ring, 1);
    pulse_snooze();
    check_val("scnt_cleared", snooze_active, 1);
    pulse_stop();
    check_val("snz_stop_active", snooze_active, 0);
    check_val("snz_stop_ring", alarm_ring, 0);

    // Next day: auto-timeout after RING_TIMEOUT_SEC ticks
    do_tick(7, 29, 59);
    do_tick(7, 30, 0);
    check_val("day2_ring", alarm_ring, 1);
    for (int i = 1; i <= 60; i++) begin
      do_tick(7, 30 + i / 60, i % 60);
      if (i == 59) check_val("timeout_before", alarm_ring, 1);
    end
    check_val("timeout_after", alarm_ring, 0);
    do_tick(7, 30, 30);
    check_val("no_retrigger", alarm_ring, 0);
    do_tick(7, 29, 59);
    do_tick(7, 30, 0);
    check_val("next_day_ring", alarm_ring, 1);

    // Out-of-range sets while ringing, then an accepted set cancels the event
    pulse_set(24, 10);
    check_val("err_pulse", set_err, 1);
    check_val("err_keep_hr", alarm_hr, 7);
    check_val("err_keep_min", alarm_min, 30);
    check_val("err_still_ring", alarm_ring, 1);
    cyc();
    check_val("err_clear", set_err, 0);
    pulse_set(23, 60);
    check_val("err_min60", set_err, 1);
    pulse_set(7, 30);
    check_val("set_cancel_ring", alarm_ring, 0);
    check_val("set_cancel_err", set_err, 0);

    // Disarm with stop and snooze in the same cycle
    do_tick(7, 29, 59);
    do_tick(7, 30, 0);
    check_val("pre_off_ring", alarm_ring, 1);
    alarm_en = 1'b0; stop = 1'b1; snooze = 1'b1;
    cyc();
    check_val("en_off_ring", alarm_ring, 0);
    check_val("en_off_snz", snooze_active, 0);
    cyc();
    alarm_en = 1'b1;
    cyc();

    // Reset in the middle of a snooze
    do_tick(7, 29, 59);
    do_tick(7, 30, 0);
    pulse_snooze();
    check_val("pre_rst_snz", snooze_active, 1);
    reset = 1'b1;
    cyc();
    check_val("mid_rst_ring", alarm_ring, 0);
    check_val("mid_rst_snz", snooze_active, 0);
    check_val("mid_rst_hr", alarm_hr, 0);
    check_val("mid_rst_min", alarm_min, 0);
    check_val("mid_rst_err", set_err, 0);
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Alarm stage directly downstream of the time-of-day counter. Consumes the binary countHr/countMin/countSec values and a 1 Hz tick, and holds a user-programmed alarm time. Drives the ring output, with snooze, a snooze-count limit, stop and an auto-timeout. Its output feeds the buzzer/LED driver.

Parameters:
SNOOZE_MIN, 5, minutes added to the current time when snooze is accepted (1..59)
MAX_SNOOZE, 3, snoozes accepted per alarm event; further snooze presses act as stop
RING_TIMEOUT_SEC, 60, ticks of continuous ringing before auto-stop (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle pulse; count* inputs hold the new second value in this cycle
countHr  in  8  current hour, binary 0..23
countMin  in  8  current minute, binary 0..59
countSec  in  8  current second, binary 0..59
alarm_en  in  1  level; 0 disarms the alarm
set_alarm  in  1  one-cycle pulse; latch alarm_hr_in/alarm_min_in
alarm_hr_in  in  8  requested alarm hour
alarm_min_in  in  8  requested alarm minute
snooze  in  1  one-cycle pulse
stop  in  1  one-cycle pulse
alarm_ring  out  1  registered ring request
snooze_active  out  1  high while in SNOOZE
alarm_hr  out  8  stored alarm hour
alarm_min  out  8  stored alarm minute
set_err  out  1  one-cycle pulse; set_alarm carried out-of-range values

Behaviour:
- Synchronous, active-high reset. All state changes on posedge clk.
- Reset values: state=IDLE, alarm_hr=0, alarm_min=0, alarm_ring=0, snooze_active=0, set_err=0, snooze_cnt=0, ring_cnt=0.
- States: IDLE, ARMED, RINGING, SNOOZE.
- IDLE -> ARMED when alarm_en=1.
- alarm_en=0 in any state -> IDLE next cycle. alarm_ring and snooze_active drop on that same edge.
- set_alarm, value check:
  - Accepted only if alarm_hr_in<=23 and alarm_min_in<=59; alarm_hr/alarm_min update on the next edge.
  - Out-of-range values: stored alarm time unchanged; set_err=1 for one cycle.
- set_alarm, state effect: an accepted set in RINGING or SNOOZE cancels the event and goes to ARMED (if alarm_en=1); snooze_cnt clears. A set in IDLE or ARMED does not change state.
- Match condition: tick_1hz=1 and countSec=0 and countHr:countMin equals the target time. The countSec=0 qualification makes each match fire exactly once.
- ARMED: target is alarm_hr:alarm_min. On match -> RINGING; alarm_ring=1 from the following edge (1-cycle latency). ring_cnt clears.
- RINGING:
  - Each tick increments ring_cnt.
  - When ring_cnt reaches RING_TIMEOUT_SEC -> ARMED; snooze_cnt clears.
  - stop -> ARMED; snooze_cnt clears.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZE. Latch snz target = (countHr:countMin)+SNOOZE_MIN, with minutes wrapping at 60 (carry into hour) and hours wrapping at 24 (23:58+5 -> 00:03). Increment snooze_cnt.
  - snooze with snooze_cnt=MAX_SNOOZE is treated as stop.
- SNOOZE: alarm_ring=0, snooze_active=1. On match against the snz target -> RINGING, ring_cnt clears. stop -> ARMED, snooze_cnt clears.
- Simultaneous events, priority: reset > alarm_en=0 > accepted set_alarm > stop > timeout > snooze > match.
- The alarm re-arms daily. Return to ARMED never blocks the next day's match.
- Arithmetic: all compares on 8-bit binary values. The wrap adder works on 8-bit values with no overflow beyond 23:59.

Decomposition:
- Package alarm_pkg: state encoding (2-bit: IDLE=00, ARMED=01, RINGING=10, SNOOZE=11) and constants MAX_HR=23, MAX_MIN=59.
- Sub-module time_add_wrap: combinational hr:min + N minutes with 60/24 wrap. Also reused by the future timer block.

Test Plan:
- Set alarm 07:30, alarm_en=1, drive time 07:29:59 -> tick to 07:30:00 -> alarm_ring=1 one cycle after that tick; stop -> alarm_ring=0, state ARMED.
- Ringing at 23:58:00, snooze -> snooze_active=1; ring resumes at 00:03:00 (hour and day wrap).
- MAX_SNOOZE=3: snooze three times, then the 4th snooze press -> alarm_ring=0, state ARMED, snooze_cnt=0.
- Ring with no input -> alarm_ring falls after 60 ticks; time 07:30:xx with xx>0 never re-triggers; alarm_ring=1 again at 07:30:00 the next day.
- set_alarm with hr=24, min=10 -> set_err pulse; alarm_hr/alarm_min keep the previous 07:30.
- Ringing: alarm_en=0 together with stop and snooze -> IDLE next cycle, alarm_ring=0. Then reset asserted mid-SNOOZE -> all outputs return to reset values.
